// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and constants for the DMA FIFO to AXI writer
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        ADDR,
        DATA,
        RESP
    } state_t;

    localparam logic [1:0] BURST_INCR     = 2'b01;
    localparam logic [1:0] RESP_OKAY      = 2'b00;
    localparam int         BOUNDARY_BYTES = 4096;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dma_burst_len.sv
// rtl/dma_burst_len.sv - burst length limited by words left, MAX_BURST and the 4 KB page
module dma_burst_len
    import dma_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int MAX_BURST = 16
) (
    input  logic [15:0] remaining,
    input  logic [11:0] addr_ofs,
    output logic [8:0]  blen
);

    localparam int BSHIFT = clog2(DWIDTH / 8);
    localparam int BL_W   = clog2(BOUNDARY_BYTES) + 1;

    logic [BL_W-1:0] bytes_left;
    logic [16:0]     to_boundary;
    logic [16:0]     cap;

    // addr_ofs is the byte offset within the current 4 KB page
    always_comb begin
        bytes_left  = BL_W'(BOUNDARY_BYTES) - {1'b0, addr_ofs};
        to_boundary = 17'(bytes_left >> BSHIFT);
        cap         = (to_boundary < 17'(MAX_BURST)) ? to_boundary : 17'(MAX_BURST);
        blen        = ({1'b0, remaining} < cap) ? 9'(remaining) : 9'(cap);
    end

endmodule

// File: rtl/dma_fifo_axi_writer.sv
// rtl/dma_fifo_axi_writer.sv - drains a show-ahead FIFO into AXI4 INCR write bursts
module dma_fifo_axi_writer
    import dma_pkg::*;
#(
    parameter int DWIDTH      = 32,
    parameter int FIFO_AWIDTH = 5,
    parameter int ADDR_W      = 32,
    parameter int MAX_BURST   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic [ADDR_W-1:0]     cfg_base_addr,
    input  logic [15:0]           cfg_len_words,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  fifo_pull,
    input  logic [DWIDTH-1:0]     fifo_data,
    input  logic                  fifo_empty,
    input  logic [FIFO_AWIDTH:0]  fifo_depth_left,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [DWIDTH-1:0]     wdata,
    output logic [DWIDTH/8-1:0]   wstrb,
    output logic                  wlast,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp
);

    localparam int BYTES  = DWIDTH / 8;
    localparam int BSHIFT = clog2(BYTES);
    localparam int OCC_W  = FIFO_AWIDTH + 1;
    localparam int DEPTH  = 1 << FIFO_AWIDTH;

    state_t            state, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       remaining_q;
    logic [8:0]        blen_q;
    logic [8:0]        blen_calc;
    logic [7:0]        beat_q;
    logic [OCC_W-1:0]  occupancy;
    logic              fifo_ready;
    logic              resp_err;
    logic              last_burst;

    dma_burst_len #(
        .DWIDTH    (DWIDTH),
        .MAX_BURST (MAX_BURST)
    ) u_burst_len (
        .remaining (remaining_q),
        .addr_ofs  (addr_q[11:0]),
        .blen      (blen_calc)
    );

    // The whole burst must already sit in the FIFO so W never starves mid-burst
    assign occupancy  = OCC_W'(DEPTH) - fifo_depth_left;
    assign fifo_ready = !fifo_empty && (17'(occupancy) >= 17'(blen_calc));
    assign resp_err   = (bresp != RESP_OKAY);
    assign last_burst = (remaining_q == 16'(blen_q));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        wlast     = 1'b0;
        bready    = 1'b0;
        fifo_pull = 1'b0;
        wdata     = fifo_data;
        wstrb     = '1;
        awsize    = 3'(BSHIFT);
        awburst   = BURST_INCR;
        case (state)
            IDLE: begin
                if (cfg_start && (cfg_len_words != 16'd0)) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (fifo_ready) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                awvalid = 1'b1;
                if (awready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                wvalid    = 1'b1;
                wlast     = (beat_q == awlen);
                fifo_pull = wready;
                if (wready && wlast) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    state_d = (resp_err || last_burst) ? IDLE : CALC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
            blen_q      <= '0;
            beat_q      <= '0;
            awaddr      <= '0;
            awlen       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        addr_q      <= cfg_base_addr & ~ADDR_W'(BYTES - 1);
                        remaining_q <= cfg_len_words;
                        err         <= 1'b0;
                        busy        <= (cfg_len_words != 16'd0);
                        done        <= (cfg_len_words == 16'd0);
                    end
                end
                CALC: begin
                    if (fifo_ready) begin
                        awaddr <= addr_q;
                        awlen  <= 8'(blen_calc - 9'd1);
                        blen_q <= blen_calc;
                        beat_q <= '0;
                    end
                end
                DATA: begin
                    if (wready) begin
                        beat_q <= beat_q + 8'd1;
                    end
                end
                RESP: begin
                    if (bvalid) begin
                        if (resp_err) begin
                            err  <= 1'b1;
                            done <= 1'b1;
                            busy <= 1'b0;
                        end else begin
                            addr_q      <= addr_q + (ADDR_W'(blen_q) << BSHIFT);
                            remaining_q <= remaining_q - 16'(blen_q);
                            if (last_burst) begin
                                done <= 1'b1;
                                busy <= 1'b0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
